// File: rtl/keycode_cmd_decoder.sv
// Turns the NIOS keycode PIO word into per-player move/bomb command tokens.
// Move keys auto-repeat on VGA frame ticks; each player has a valid/ready output port.
module keycode_cmd_decoder #(
    parameter int unsigned INIT_FRAMES   = 12,
    parameter int unsigned REPEAT_FRAMES = 4,
    parameter int unsigned CNT_W         = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] Keycode,
    input  logic        Frame_VS,
    input  logic        Cmd_Ready_1,
    output logic        Cmd_Valid_1,
    output logic        Cmd_Bomb_1,
    output logic [1:0]  Cmd_Dir_1,
    input  logic        Cmd_Ready_2,
    output logic        Cmd_Valid_2,
    output logic        Cmd_Bomb_2,
    output logic [1:0]  Cmd_Dir_2
);

    typedef enum logic [1:0] {StIdle, StHeldDelay, StHeldRepeat} state_e;

    localparam logic [CNT_W-1:0] InitCnt   = CNT_W'(INIT_FRAMES);
    localparam logic [CNT_W-1:0] RepeatCnt = CNT_W'(REPEAT_FRAMES);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    // Returns {hit, dir} for one keycode slot of the selected player.
    function automatic logic [2:0] move_lookup(input logic [7:0] code, input logic p2);
        logic [2:0] r;
        r = 3'b000;
        if (!p2) begin
            case (code)
                8'h1A:   r = 3'b100;
                8'h16:   r = 3'b101;
                8'h04:   r = 3'b110;
                8'h07:   r = 3'b111;
                default: r = 3'b000;
            endcase
        end else begin
            case (code)
                8'h52:   r = 3'b100;
                8'h51:   r = 3'b101;
                8'h50:   r = 3'b110;
                8'h4F:   r = 3'b111;
                default: r = 3'b000;
            endcase
        end
        return r;
    endfunction

    logic [15:0]      key_q;
    logic             vs_s1_q, vs_s2_q, vs_s3_q;
    logic             tick;

    logic [2:0]       look0 [2];
    logic [2:0]       look1 [2];
    logic [1:0]       dec_hit, dec_bomb;
    logic [1:0]       dec_dir [2];

    logic [1:0]       prev_hit_q, prev_bomb_q;
    logic [1:0]       prev_dir_q [2];
    logic [1:0]       press, bomb_edge, queue_move;

    state_e           state_q [2];
    state_e           state_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic [1:0]       move_pend_q, move_pend_d, bomb_pend_q, bomb_pend_d;
    logic [1:0]       move_dir_q [2];
    logic [1:0]       move_dir_d [2];
    logic [1:0]       ready, valid, xfer;

    // Keycode register and Frame_VS synchronizer; stage 3 only serves edge detection.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            key_q   <= 16'h0000;
            vs_s1_q <= 1'b1;
            vs_s2_q <= 1'b1;
            vs_s3_q <= 1'b1;
        end else begin
            key_q   <= Keycode;
            vs_s1_q <= Frame_VS;
            vs_s2_q <= vs_s1_q;
            vs_s3_q <= vs_s2_q;
        end
    end

    assign tick = vs_s3_q & ~vs_s2_q;

    // Slot 0 wins when both slots carry a move key of the same player.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            look0[p]   = move_lookup(key_q[7:0], p == 1);
            look1[p]   = move_lookup(key_q[15:8], p == 1);
            dec_hit[p] = look0[p][2] | look1[p][2];
            dec_dir[p] = look0[p][2] ? look0[p][1:0] : look1[p][1:0];
        end
        dec_bomb[0] = (key_q[7:0] == 8'h2C) | (key_q[15:8] == 8'h2C);
        dec_bomb[1] = (key_q[7:0] == 8'h28) | (key_q[15:8] == 8'h28);
    end

    always_comb begin
        press      = '0;
        bomb_edge  = '0;
        queue_move = '0;
        for (int p = 0; p < 2; p++) begin
            press[p]     = dec_hit[p] & (~prev_hit_q[p] | (dec_dir[p] != prev_dir_q[p]));
            bomb_edge[p] = dec_bomb[p] & ~prev_bomb_q[p];
            state_d[p]   = state_q[p];
            cnt_d[p]     = cnt_q[p];
            if (!dec_hit[p]) begin
                state_d[p] = StIdle;
                cnt_d[p]   = '0;
            end else if (press[p]) begin
                queue_move[p] = 1'b1;
                cnt_d[p]      = '0;
                state_d[p]    = StHeldDelay;
            end else if (tick) begin
                case (state_q[p])
                    StHeldDelay: begin
                        if ((cnt_q[p] + CntOne) == InitCnt) begin
                            queue_move[p] = 1'b1;
                            cnt_d[p]      = '0;
                            state_d[p]    = StHeldRepeat;
                        end else begin
                            cnt_d[p] = cnt_q[p] + CntOne;
                        end
                    end
                    StHeldRepeat: begin
                        if ((cnt_q[p] + CntOne) == RepeatCnt) begin
                            queue_move[p] = 1'b1;
                            cnt_d[p]      = '0;
                        end else begin
                            cnt_d[p] = cnt_q[p] + CntOne;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A new queue event takes priority over a same-cycle transfer, so it stays pending.
    always_comb begin
        ready = {Cmd_Ready_2, Cmd_Ready_1};
        valid = move_pend_q | bomb_pend_q;
        xfer  = valid & ready;
        for (int p = 0; p < 2; p++) begin
            move_pend_d[p] = queue_move[p] |
                             (move_pend_q[p] & ~(xfer[p] & ~bomb_pend_q[p]));
            move_dir_d[p]  = queue_move[p] ? dec_dir[p] : move_dir_q[p];
            bomb_pend_d[p] = bomb_edge[p] | (bomb_pend_q[p] & ~xfer[p]);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            prev_hit_q  <= '0;
            prev_bomb_q <= '0;
            move_pend_q <= '0;
            bomb_pend_q <= '0;
            for (int p = 0; p < 2; p++) begin
                prev_dir_q[p] <= 2'b00;
                state_q[p]    <= StIdle;
                cnt_q[p]      <= '0;
                move_dir_q[p] <= 2'b00;
            end
        end else begin
            prev_hit_q  <= dec_hit;
            prev_bomb_q <= dec_bomb;
            move_pend_q <= move_pend_d;
            bomb_pend_q <= bomb_pend_d;
            for (int p = 0; p < 2; p++) begin
                prev_dir_q[p] <= dec_dir[p];
                state_q[p]    <= state_d[p];
                cnt_q[p]      <= cnt_d[p];
                move_dir_q[p] <= move_dir_d[p];
            end
        end
    end

    // Bomb is presented ahead of any pending move.
    assign Cmd_Valid_1 = valid[0];
    assign Cmd_Bomb_1  = bomb_pend_q[0];
    assign Cmd_Dir_1   = bomb_pend_q[0] ? 2'b00 : move_dir_q[0];
    assign Cmd_Valid_2 = valid[1];
    assign Cmd_Bomb_2  = bomb_pend_q[1];
    assign Cmd_Dir_2   = bomb_pend_q[1] ? 2'b00 : move_dir_q[1];

endmodule

// File: tb/tb_keycode_cmd_decoder.sv
// Bench for keycode_cmd_decoder: per-cycle comparison against a frame-count model
// plus directed scenarios with hand-computed expectations.
module tb_keycode_cmd_decoder;

    localparam int Init = 12;
    localparam int Rep  = 4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] Keycode;
    logic        Frame_VS;
    logic        Cmd_Ready_1, Cmd_Ready_2;
    logic        Cmd_Valid_1, Cmd_Bomb_1, Cmd_Valid_2, Cmd_Bomb_2;
    logic [1:0]  Cmd_Dir_1, Cmd_Dir_2;

    int checks = 0;
    int errors = 0;
    int pulses1 = 0;
    int pulses2 = 0;

    always #5 Clk = ~Clk;

    keycode_cmd_decoder #(
        .INIT_FRAMES  (Init),
        .REPEAT_FRAMES(Rep),
        .CNT_W        (6)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Keycode    (Keycode),
        .Frame_VS   (Frame_VS),
        .Cmd_Ready_1(Cmd_Ready_1),
        .Cmd_Valid_1(Cmd_Valid_1),
        .Cmd_Bomb_1 (Cmd_Bomb_1),
        .Cmd_Dir_1  (Cmd_Dir_1),
        .Cmd_Ready_2(Cmd_Ready_2),
        .Cmd_Valid_2(Cmd_Valid_2),
        .Cmd_Bomb_2 (Cmd_Bomb_2),
        .Cmd_Dir_2  (Cmd_Dir_2)
    );

    // Model: direction index is the position in the player's key list (up, down, left, right).
    int move_codes [2][4] = '{'{'h1A, 'h16, 'h04, 'h07}, '{'h52, 'h51, 'h50, 'h4F}};
    int bomb_codes [2]    = '{'h2C, 'h28};

    logic [15:0] m_key;
    bit          m_s1, m_s2, m_s3;
    int          m_prev [2];
    bit          m_prev_bomb [2];
    int          m_ticks [2];
    int          m_move [2];
    bit          m_bomb [2];
    bit          model_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_dir(input int p, input logic [15:0] k);
        int c;
        for (int s = 0; s < 2; s++) begin
            c = (s == 0) ? int'(k[7:0]) : int'(k[15:8]);
            for (int d = 0; d < 4; d++)
                if (c == move_codes[p][d]) return d;
        end
        return -1;
    endfunction

    function automatic bit has_bomb(input int p, input logic [15:0] k);
        return (int'(k[7:0]) == bomb_codes[p]) || (int'(k[15:8]) == bomb_codes[p]);
    endfunction

    task automatic model_step();
        bit tick, b, fire, rdy;
        int dir;
        if (!Reset_n) begin
            m_key = 16'h0000;
            m_s1 = 1; m_s2 = 1; m_s3 = 1;
            for (int p = 0; p < 2; p++) begin
                m_prev[p] = -1; m_prev_bomb[p] = 0; m_ticks[p] = 0;
                m_move[p] = -1; m_bomb[p] = 0;
            end
            model_ok = 1'b1;
            return;
        end
        tick = m_s3 && !m_s2;
        for (int p = 0; p < 2; p++) begin
            rdy = (p == 0) ? Cmd_Ready_1 : Cmd_Ready_2;
            if (rdy && (m_bomb[p] || m_move[p] >= 0)) begin
                if (m_bomb[p]) m_bomb[p] = 0;
                else m_move[p] = -1;
            end
            dir  = find_dir(p, m_key);
            b    = has_bomb(p, m_key);
            fire = 0;
            if (dir >= 0) begin
                if (dir != m_prev[p]) begin
                    fire = 1;
                    m_ticks[p] = 0;
                end else if (tick) begin
                    m_ticks[p]++;
                    fire = (m_ticks[p] == Init) ||
                           (m_ticks[p] > Init && (m_ticks[p] - Init) % Rep == 0);
                end
            end
            if (fire) m_move[p] = dir;
            if (b && !m_prev_bomb[p]) m_bomb[p] = 1;
            m_prev[p]      = dir;
            m_prev_bomb[p] = b;
        end
        m_key = Keycode;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = Frame_VS;
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    // Dir is only meaningful while Valid is high.
    initial forever begin
        @(negedge Clk);
        if (model_ok) begin
            for (int p = 0; p < 2; p++) begin
                bit ev;
                int ed;
                ev = m_bomb[p] || (m_move[p] >= 0);
                ed = m_bomb[p] ? 0 : m_move[p];
                if (p == 0) begin
                    chk("model_valid_1", 32'(Cmd_Valid_1), 32'(ev));
                    chk("model_bomb_1", 32'(Cmd_Bomb_1), 32'(m_bomb[p]));
                    if (ev) chk("model_dir_1", 32'(Cmd_Dir_1), 32'(ed));
                end else begin
                    chk("model_valid_2", 32'(Cmd_Valid_2), 32'(ev));
                    chk("model_bomb_2", 32'(Cmd_Bomb_2), 32'(m_bomb[p]));
                    if (ev) chk("model_dir_2", 32'(Cmd_Dir_2), 32'(ed));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge Clk);
            pulses1 += int'(Cmd_Valid_1);
            pulses2 += int'(Cmd_Valid_2);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            Frame_VS = 1'b0;
            cyc(3);
            Frame_VS = 1'b1;
            cyc(3);
        end
    endtask

    task automatic drain();
        Keycode = 16'h0000;
        Cmd_Ready_1 = 1'b1;
        Cmd_Ready_2 = 1'b1;
        cyc(3);
    endtask

    initial begin
        Reset_n = 1'b0;
        Keycode = 16'h001A;
        Frame_VS = 1'b1;
        Cmd_Ready_1 = 1'b0;
        Cmd_Ready_2 = 1'b0;

        // 1: reset with W held, then fresh press two cycles after release
        cyc(5);
        chk("t1_rst_valid_1", 32'(Cmd_Valid_1), 0);
        chk("t1_rst_valid_2", 32'(Cmd_Valid_2), 0);
        chk("t1_rst_outs", 32'({Cmd_Bomb_1, Cmd_Dir_1, Cmd_Bomb_2, Cmd_Dir_2}), 0);
        Reset_n = 1'b1;
        cyc(1);
        chk("t1_valid_1cyc", 32'(Cmd_Valid_1), 0);
        cyc(1);
        chk("t1_valid_2cyc", 32'(Cmd_Valid_1), 1);
        chk("t1_dir_up", 32'(Cmd_Dir_1), 0);
        Cmd_Ready_1 = 1'b1;
        cyc(1);
        chk("t1_accepted", 32'(Cmd_Valid_1), 0);

        // 2: auto-repeat cadence 12 then every 4 frames
        drain();
        pulses1 = 0;
        Keycode = 16'h001A;
        cyc(4);
        chk("t2_first_pulse", 32'(pulses1), 1);
        frames(11);
        chk("t2_no_early_repeat", 32'(pulses1), 1);
        frames(1);
        chk("t2_first_repeat", 32'(pulses1), 2);
        frames(3);
        chk("t2_repeat_gap", 32'(pulses1), 2);
        frames(1);
        chk("t2_second_repeat", 32'(pulses1), 3);
        frames(8);
        chk("t2_more_repeats", 32'(pulses1), 5);
        Keycode = 16'h0000;
        cyc(2);
        frames(8);
        chk("t2_release_stops", 32'(pulses1), 5);

        // 3: bomb presented before move
        drain();
        Cmd_Ready_1 = 1'b0;
        Keycode = 16'h002C;
        cyc(3);
        Keycode = 16'h0007;
        cyc(3);
        chk("t3_valid", 32'(Cmd_Valid_1), 1);
        chk("t3_bomb_first", 32'(Cmd_Bomb_1), 1);
        chk("t3_bomb_dir0", 32'(Cmd_Dir_1), 0);
        Cmd_Ready_1 = 1'b1;
        cyc(1);
        chk("t3_move_valid", 32'(Cmd_Valid_1), 1);
        chk("t3_move_bomb0", 32'(Cmd_Bomb_1), 0);
        chk("t3_move_right", 32'(Cmd_Dir_1), 3);
        cyc(1);
        chk("t3_empty", 32'(Cmd_Valid_1), 0);

        // 4: both players in the same cycle
        drain();
        pulses1 = 0;
        pulses2 = 0;
        Keycode = 16'h521A;
        cyc(2);
        chk("t4_valid_1", 32'(Cmd_Valid_1), 1);
        chk("t4_valid_2", 32'(Cmd_Valid_2), 1);
        chk("t4_dirs_up", 32'({Cmd_Dir_1, Cmd_Dir_2}), 0);
        cyc(1);
        chk("t4_one_pulse_each", 32'(pulses1 * 16 + pulses2), 32'h11);

        // 5: slot priority and direction change restarts the delay
        drain();
        Cmd_Ready_1 = 1'b0;
        Keycode = 16'h071A;
        cyc(2);
        chk("t5_slot0_valid", 32'(Cmd_Valid_1), 1);
        chk("t5_slot0_up", 32'(Cmd_Dir_1), 0);
        Cmd_Ready_1 = 1'b1;
        cyc(1);
        frames(6);
        Cmd_Ready_1 = 1'b0;
        Keycode = 16'h0007;
        cyc(2);
        chk("t5_change_valid", 32'(Cmd_Valid_1), 1);
        chk("t5_change_right", 32'(Cmd_Dir_1), 3);
        Cmd_Ready_1 = 1'b1;
        cyc(1);
        pulses1 = 0;
        frames(11);
        chk("t5_delay_restarted", 32'(pulses1), 0);
        frames(1);
        chk("t5_repeat_after_12", 32'(pulses1), 1);

        // 6: reset mid-repeat discards the pending move
        drain();
        Cmd_Ready_2 = 1'b0;
        Keycode = 16'h004F;
        frames(13);
        chk("t6_pending", 32'(Cmd_Valid_2), 1);
        Reset_n = 1'b0;
        cyc(1);
        chk("t6_rst_clears", 32'(Cmd_Valid_2), 0);
        Reset_n = 1'b1;
        cyc(1);
        chk("t6_release_1cyc", 32'(Cmd_Valid_2), 0);
        cyc(1);
        chk("t6_fresh_press", 32'(Cmd_Valid_2), 1);
        chk("t6_fresh_right", 32'(Cmd_Dir_2), 3);

        // 7: second bomb while flagged is dropped; dual bombs together
        drain();
        Cmd_Ready_1 = 1'b0;
        Keycode = 16'h002C;
        cyc(2);
        Keycode = 16'h0000;
        cyc(2);
        Keycode = 16'h002C;
        cyc(2);
        Keycode = 16'h0000;
        cyc(2);
        chk("t7_bomb_pending", 32'(Cmd_Bomb_1), 1);
        Cmd_Ready_1 = 1'b1;
        cyc(1);
        chk("t7_second_dropped", 32'(Cmd_Valid_1), 0);
        drain();
        Keycode = 16'h282C;
        cyc(2);
        chk("t7_dual_bombs", 32'({Cmd_Valid_1, Cmd_Bomb_1, Cmd_Valid_2, Cmd_Bomb_2}), 32'hF);
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
